// File: rtl/osc_freq_meter.sv
// Oscillator frequency meter: counts clk cycles between reference-pulse rising edges
// and hands each period to the host via valid/ack. Optional range check: OSC_FREQ_LIMIT_EN.
module osc_freq_meter #(
    parameter int unsigned CNT_W       = 32,
    parameter int unsigned SYNC_STAGES = 2,
    parameter logic [31:0] TIMEOUT     = 32'hFFFF_FFFF
`ifdef OSC_FREQ_LIMIT_EN
    ,
    parameter logic [CNT_W-1:0] FREQ_MIN = '0,
    parameter logic [CNT_W-1:0] FREQ_MAX = '0
`endif
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ref_in,
    input  logic             enable,
    output logic [CNT_W-1:0] freq_count,
    output logic             freq_valid,
    input  logic             freq_ack,
    output logic             overrun,
    output logic             saturated,
    output logic             ref_lost
`ifdef OSC_FREQ_LIMIT_EN
    ,
    output logic             freq_ok
`endif
);

    localparam int unsigned TMO_W = 32;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARM     = 2'd1,
        MEASURE = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   ref_prev;
    logic                   ref_edge_c;

    logic [CNT_W-1:0] cnt;
    logic             cnt_max_c;
    logic [TMO_W-1:0] tmo_cnt;
    logic             tmo_hit_c;

    logic cnt_load_c;
    logic cnt_inc_c;
    logic capture_c;
    logic tmo_run_c;
    logic tmo_fire_c;
    logic load_c;

    // Reference synchronizer and rising-edge detect
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q   <= '0;
            ref_prev <= 1'b0;
        end else begin
            sync_q   <= {sync_q[SYNC_STAGES-2:0], ref_in};
            ref_prev <= sync_q[SYNC_STAGES-1];
        end
    end

    assign ref_edge_c = sync_q[SYNC_STAGES-1] & ~ref_prev;
    assign cnt_max_c  = (cnt == {CNT_W{1'b1}});
    assign tmo_hit_c  = (tmo_cnt == (TIMEOUT - 32'd1));

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_next = state;
        if (!enable) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE:    state_next = ARM;
                ARM:     if (ref_edge_c) state_next = MEASURE;
                MEASURE: if (!ref_edge_c && tmo_hit_c) state_next = ARM;
                default: state_next = IDLE;
            endcase
        end
    end

    // FSM control outputs
    always_comb begin
        cnt_load_c = 1'b0;
        cnt_inc_c  = 1'b0;
        capture_c  = 1'b0;
        tmo_run_c  = 1'b0;
        tmo_fire_c = 1'b0;
        if (enable) begin
            case (state)
                ARM: begin
                    cnt_load_c = ref_edge_c;
                    tmo_run_c  = 1'b1;
                    tmo_fire_c = !ref_edge_c && tmo_hit_c;
                end
                MEASURE: begin
                    capture_c  = ref_edge_c;
                    cnt_load_c = ref_edge_c;
                    cnt_inc_c  = !ref_edge_c && !tmo_hit_c;
                    tmo_run_c  = 1'b1;
                    tmo_fire_c = !ref_edge_c && tmo_hit_c;
                end
                default: begin
                    cnt_load_c = 1'b0;
                end
            endcase
        end
    end

    // Period counter: restarts at 1 on each edge, clamps at all-ones, else held at 0
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (cnt_load_c) begin
            cnt <= CNT_W'(1);
        end else if (cnt_inc_c) begin
            cnt <= cnt_max_c ? cnt : cnt + CNT_W'(1);
        end else begin
            cnt <= '0;
        end
    end

    // Edge-starvation timer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_cnt <= '0;
        end else if (tmo_run_c && !ref_edge_c && !tmo_fire_c) begin
            tmo_cnt <= tmo_cnt + TMO_W'(1);
        end else begin
            tmo_cnt <= '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ref_lost <= 1'b0;
        end else if (ref_edge_c) begin
            ref_lost <= 1'b0;
        end else if (tmo_fire_c) begin
            ref_lost <= 1'b1;
        end
    end

    // A capture is accepted if the slot is free or being acknowledged this cycle
    assign load_c = capture_c && (!freq_valid || freq_ack);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            freq_count <= '0;
            freq_valid <= 1'b0;
            saturated  <= 1'b0;
        end else if (load_c) begin
            freq_count <= cnt;
            freq_valid <= 1'b1;
            saturated  <= cnt_max_c;
        end else if (freq_ack) begin
            freq_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overrun <= 1'b0;
        end else if (freq_valid && freq_ack) begin
            overrun <= 1'b0;
        end else if (capture_c && freq_valid) begin
            overrun <= 1'b1;
        end
    end

`ifdef OSC_FREQ_LIMIT_EN
    logic in_range_c;
    assign in_range_c = (cnt >= FREQ_MIN) && (cnt <= FREQ_MAX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            freq_ok <= 1'b0;
        end else if (load_c) begin
            freq_ok <= in_range_c;
        end
    end
`endif

endmodule

// File: tb/tb_osc_freq_meter.sv
// Bench for osc_freq_meter: period table, random periods against a rise-spacing model,
// and hand-written handshake/saturation/timeout/reset sequences.
module tb_osc_freq_meter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ref_in = 1'b0;
    logic        enable = 1'b0;
    logic        man_ack = 1'b0;
    logic        auto_ack = 1'b0;
    logic        auto_on = 1'b0;
    logic        freq_ack;
    logic [31:0] freq_count;
    logic        freq_valid, overrun, saturated, ref_lost;

    logic        en8 = 1'b0;
    logic        ack8 = 1'b0;
    logic [7:0]  count8;
    logic        valid8, overrun8, sat8, lost8;
`ifdef OSC_FREQ_LIMIT_EN
    logic        freq_ok, ok8;
`endif

    assign freq_ack = auto_on ? auto_ack : man_ack;

    always #5 clk = ~clk;

    osc_freq_meter #(
        .CNT_W(32), .SYNC_STAGES(2), .TIMEOUT(32'd2000)
`ifdef OSC_FREQ_LIMIT_EN
        , .FREQ_MIN(32'd990), .FREQ_MAX(32'd1010)
`endif
    ) dut (
        .clk(clk), .rst_n(rst_n), .ref_in(ref_in), .enable(enable),
        .freq_count(freq_count), .freq_valid(freq_valid), .freq_ack(freq_ack),
        .overrun(overrun), .saturated(saturated), .ref_lost(ref_lost)
`ifdef OSC_FREQ_LIMIT_EN
        , .freq_ok(freq_ok)
`endif
    );

    osc_freq_meter #(
        .CNT_W(8), .SYNC_STAGES(2), .TIMEOUT(32'd2000)
    ) dut8 (
        .clk(clk), .rst_n(rst_n), .ref_in(ref_in), .enable(en8),
        .freq_count(count8), .freq_valid(valid8), .freq_ack(ack8),
        .overrun(overrun8), .saturated(sat8), .ref_lost(lost8)
`ifdef OSC_FREQ_LIMIT_EN
        , .freq_ok(ok8)
`endif
    );

    typedef struct {
        int unsigned period;
        logic [31:0] cnt;
        logic        ok;
    } vec_t;

    typedef struct {
        logic [31:0] cnt;
        logic        ok;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    vec_t tab[10];
    int   n_tests = 0;
    int   n_fail = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic wait_neg(input int n);
        repeat (n) @(negedge clk);
    endtask

    // One reference period: rise now, next rise is p cycles later
    task automatic gate(input int unsigned p);
        ref_in = 1'b1;
        wait_neg(4);
        ref_in = 1'b0;
        wait_neg(int'(p) - 4);
    endtask

    task automatic final_rise();
        ref_in = 1'b1;
        wait_neg(4);
        ref_in = 1'b0;
        wait_neg(10);
    endtask

    task automatic push_exp(input logic [31:0] c, input logic ok);
        exp_t e;
        e.cnt = c;
        e.ok  = ok;
        exp_q.push_back(e);
    endtask

    task automatic drain();
        for (int i = 0; i < 50 && exp_q.size() != 0; i++) wait_neg(1);
        check("queue_drained", 64'(exp_q.size()), 64'd0);
    endtask

    task automatic restart();
        enable = 1'b0;
        wait_neg(3);
        enable = 1'b1;
        wait_neg(2);
    endtask

    function automatic logic model_ok(input int unsigned p);
        return (p >= 990) && (p <= 1010);
    endfunction

    // Auto-acknowledging result checker
    always @(negedge clk) begin
        if (auto_ack) begin
            auto_ack = 1'b0;
        end else if (auto_on && freq_valid) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL result_expected: got count %0d with no pending result", freq_count);
            end else begin
                mon_e = exp_q.pop_front();
                check("auto_count", 64'(freq_count), 64'(mon_e.cnt));
                check("auto_overrun", 64'(overrun), 64'd0);
                check("auto_saturated", 64'(saturated), 64'd0);
`ifdef OSC_FREQ_LIMIT_EN
                check("auto_freq_ok", 64'(freq_ok), 64'(mon_e.ok));
`endif
            end
            auto_ack = 1'b1;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned rp[16];

        tab[0] = '{1000, 32'd1000, 1'b1};
        tab[1] = '{500,  32'd500,  1'b0};
        tab[2] = '{700,  32'd700,  1'b0};
        tab[3] = '{990,  32'd990,  1'b1};
        tab[4] = '{1010, 32'd1010, 1'b1};
        tab[5] = '{989,  32'd989,  1'b0};
        tab[6] = '{1011, 32'd1011, 1'b0};
        tab[7] = '{40,   32'd40,   1'b0};
        tab[8] = '{1500, 32'd1500, 1'b0};
        tab[9] = '{1000, 32'd1000, 1'b1};

        // Reset state
        wait_neg(3);
        check("rst_count", 64'(freq_count), 64'd0);
        check("rst_valid", 64'(freq_valid), 64'd0);
        rst_n = 1'b1;
        wait_neg(2);
        check("rst_overrun", 64'(overrun), 64'd0);
        check("rst_saturated", 64'(saturated), 64'd0);
        check("rst_ref_lost", 64'(ref_lost), 64'd0);
`ifdef OSC_FREQ_LIMIT_EN
        check("rst_freq_ok", 64'(freq_ok), 64'd0);
`endif

        // Table of periods, every result acknowledged
        enable  = 1'b1;
        auto_on = 1'b1;
        wait_neg(2);
        for (int i = 0; i < 10; i++) begin
            if (i > 0) push_exp(tab[i-1].cnt, tab[i-1].ok);
            gate(tab[i].period);
        end
        push_exp(tab[9].cnt, tab[9].ok);
        final_rise();
        drain();

        // Random periods against the rise-spacing model
        restart();
        for (int i = 0; i < 16; i++) rp[i] = $urandom_range(1500, 40);
        for (int i = 0; i < 16; i++) begin
            if (i > 0) push_exp(rp[i-1], model_ok(rp[i-1]));
            gate(rp[i]);
        end
        push_exp(rp[15], model_ok(rp[15]));
        final_rise();
        drain();

        // Unacknowledged back-to-back results: second one dropped
        auto_on = 1'b0;
        restart();
        gate(500);
        ref_in = 1'b1;
        wait_neg(2);
        check("latency_early_valid", 64'(freq_valid), 64'd0);
        wait_neg(2);
        check("latency_late_valid", 64'(freq_valid), 64'd1);
        ref_in = 1'b0;
        wait_neg(696);
        final_rise();
        check("ovr_count", 64'(freq_count), 64'd500);
        check("ovr_valid", 64'(freq_valid), 64'd1);
        check("ovr_overrun", 64'(overrun), 64'd1);
        man_ack = 1'b1;
        wait_neg(1);
        man_ack = 1'b0;
        check("ovr_ack_valid", 64'(freq_valid), 64'd0);
        check("ovr_ack_overrun", 64'(overrun), 64'd0);

        // Ack in the same cycle as a new capture
        restart();
        gate(200);
        gate(800);
        check("same_pre_count", 64'(freq_count), 64'd200);
        check("same_pre_valid", 64'(freq_valid), 64'd1);
        ref_in = 1'b1;
        wait_neg(2);
        man_ack = 1'b1;
        wait_neg(1);
        man_ack = 1'b0;
        wait_neg(2);
        ref_in = 1'b0;
        check("same_count", 64'(freq_count), 64'd800);
        check("same_valid", 64'(freq_valid), 64'd1);
        check("same_overrun", 64'(overrun), 64'd0);
        man_ack = 1'b1;
        wait_neg(1);
        man_ack = 1'b0;
        check("same_ack_valid", 64'(freq_valid), 64'd0);

        // 8-bit counter saturation then recovery
        enable = 1'b0;
        en8    = 1'b1;
        wait_neg(2);
        gate(300);
        ref_in = 1'b1;
        wait_neg(6);
        check("sat_count", 64'(count8), 64'hFF);
        check("sat_flag", 64'(sat8), 64'd1);
        check("sat_valid", 64'(valid8), 64'd1);
        ack8 = 1'b1;
        wait_neg(1);
        ack8 = 1'b0;
        check("sat_ack_valid", 64'(valid8), 64'd0);
        ref_in = 1'b0;
        wait_neg(93);
        ref_in = 1'b1;
        wait_neg(6);
        ref_in = 1'b0;
        check("unsat_count", 64'(count8), 64'd100);
        check("unsat_flag", 64'(sat8), 64'd0);
        check("unsat_valid", 64'(valid8), 64'd1);
        ack8 = 1'b1;
        wait_neg(1);
        ack8 = 1'b0;
        en8 = 1'b0;

        // Reference stuck low after arming
        auto_on = 1'b1;
        restart();
        ref_in = 1'b1;
        wait_neg(4);
        ref_in = 1'b0;
        wait_neg(1991);
        check("lost_before_timeout", 64'(ref_lost), 64'd0);
        wait_neg(15);
        check("lost_after_timeout", 64'(ref_lost), 64'd1);
        check("lost_no_result", 64'(freq_valid), 64'd0);
        gate(1000);
        check("lost_cleared", 64'(ref_lost), 64'd0);
        push_exp(32'd1000, 1'b1);
        final_rise();
        drain();

        // enable dropped mid-gate, then resume
        restart();
        gate(400);
        enable = 1'b0;
        wait_neg(3);
        enable = 1'b1;
        wait_neg(2);
        gate(1000);
        push_exp(32'd1000, 1'b1);
        gate(400);

        // rst_n asserted mid-gate, then resume
        rst_n = 1'b0;
        wait_neg(3);
        check("midrst_count", 64'(freq_count), 64'd0);
        check("midrst_valid", 64'(freq_valid), 64'd0);
        check("midrst_queue", 64'(exp_q.size()), 64'd0);
        rst_n = 1'b1;
        wait_neg(2);
        gate(1000);
        push_exp(32'd1000, 1'b1);
        gate(1100);
        push_exp(32'd1100, 1'b0);
        final_rise();
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
